// File: rtl/lut_table_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_table_loader_if
// Description : Configuration, lookup and (optional) readback bundle for the
//               runtime-loadable neuron truth table. The rb_* members exist
//               only when LUT_LOADER_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lut_table_loader_if #(
  parameter int IN_BITS  = 7,
  parameter int OUT_BITS = 2,
  parameter int ENTRIES  = 4
);
  logic                         cfg_start;
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [ENTRIES*OUT_BITS-1:0]  cfg_data;
  logic                         cfg_done;
  logic                         loaded;
  logic                         in_valid;
  logic [IN_BITS-1:0]           in_data;
  logic                         out_valid;
  logic [OUT_BITS-1:0]          out_data;
  logic                         err;
`ifdef LUT_LOADER_READBACK_EN
  logic                         rb_req;
  logic [IN_BITS-1:0]           rb_addr;
  logic                         rb_valid;
  logic [OUT_BITS-1:0]          rb_data;
`endif

  // Configuration source / lookup requester side
  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_ready, cfg_done, loaded, out_valid, out_data, err
`ifdef LUT_LOADER_READBACK_EN
    , output rb_req, rb_addr
    , input  rb_valid, rb_data
`endif
  );

  // Table block side
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_ready, cfg_done, loaded, out_valid, out_data, err
`ifdef LUT_LOADER_READBACK_EN
    , input  rb_req, rb_addr
    , output rb_valid, rb_data
`endif
  );
endinterface
`default_nettype wire

// File: rtl/lut_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_table_loader
// Description : Runtime-programmable neuron truth table. A beat stream packs
//               ENTRIES table entries per beat into a 2^IN_BITS x OUT_BITS
//               distributed RAM; once loaded, registered one-cycle lookups
//               behave like a fixed neuron ROM.
//               Optional feature macro: LUT_LOADER_READBACK_EN adds an
//               independent readback port (rb_*) usable in any state.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_table_loader #(
  parameter int IN_BITS  = 7,
  parameter int OUT_BITS = 2,
  parameter int ENTRIES  = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  lut_table_loader_if.slave   bus
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int LOG_E  = $clog2(ENTRIES);
  localparam int BEAT_W = IN_BITS - LOG_E;
  localparam logic [BEAT_W-1:0] LAST_BEAT = {BEAT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  cfg_ready_q;
  logic                  cfg_done_q;
  logic                  loaded_q;
  logic                  out_valid_q;
  logic [OUT_BITS-1:0]   out_data_q;
  logic                  err_q;

  // Table storage; intentionally has no reset.
  logic [OUT_BITS-1:0]   mem [DEPTH];

  // A beat is written only when it is accepted and not overridden by a restart.
  logic                  w_wr;
  logic [IN_BITS-1:0]    w_base;

  assign w_wr   = (state_q == S_LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign w_base = IN_BITS'(beat_q) << LOG_E;

  // Write all slices of an accepted beat into consecutive table entries.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int j = 0; j < ENTRIES; j++) begin
        mem[w_base | IN_BITS'(j)] <= bus.cfg_data[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Load-sequencing FSM plus registered lookup path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE, S_RUN: begin
          if (bus.cfg_start) begin
            state_q     <= S_LOAD;
            beat_q      <= '0;
            cfg_ready_q <= 1'b1;
            loaded_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.cfg_start) begin
            // Restart wins even over a last-beat transfer.
            beat_q <= '0;
            err_q  <= 1'b1;
          end else if (bus.cfg_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q     <= S_RUN;
              beat_q      <= '0;
              cfg_ready_q <= 1'b0;
              cfg_done_q  <= 1'b1;
              loaded_q    <= 1'b1;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          beat_q      <= '0;
          cfg_ready_q <= 1'b0;
          loaded_q    <= 1'b0;
        end
      endcase

      // Lookups use the pre-edge state: the cycle entering RUN is not loaded.
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        if (state_q == S_RUN) begin
          out_data_q <= mem[bus.in_data];
        end else begin
          out_data_q <= '0;
          err_q      <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.loaded    = loaded_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;

`ifdef LUT_LOADER_READBACK_EN
  logic                rb_valid_q;
  logic [OUT_BITS-1:0] rb_data_q;

  // Independent readback mux; returns pre-write contents during a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= bus.rb_req;
      if (bus.rb_req) begin
        rb_data_q <= mem[bus.rb_addr];
      end
    end
  end

  assign bus.rb_valid = rb_valid_q;
  assign bus.rb_data  = rb_data_q;
`endif

endmodule
`default_nettype wire

// File: doc/lut_table_loader.md
# lut_table_loader

Runtime-programmable counterpart of the generated LogicNets truth-table neurons. It is the writer side of the neuron's truth table: a configuration stream loads a 2^IN_BITS-entry, OUT_BITS-wide table into distributed RAM. Once loaded, the block serves registered lookups with the same input/output semantics as a fixed neuron ROM. It lets the fid-opt network swap neuron tables without resynthesis.

## Interface
Parameters:
- IN_BITS, 7, neuron input width; table depth is 2^IN_BITS.
- OUT_BITS, 2, neuron output width.
- ENTRIES, 4, table entries packed per configuration beat; must be a power of two that divides 2^IN_BITS.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to begin or restart a table load.
- cfg_valid  in  1  configuration beat valid.
- cfg_ready  out  1  block accepts a beat; high only in LOAD.
- cfg_data  in  ENTRIES*OUT_BITS  packed entries; slice j holds entry j.
- cfg_done  out  1  one-cycle pulse after the final beat is written.
- loaded  out  1  table complete and lookups are valid.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  lookup address (neuron input).
- out_valid  out  1  lookup result valid.
- out_data  out  OUT_BITS  table[in_data].
- err  out  1  one-cycle error pulse.
- Present only with LUT_LOADER_READBACK_EN:
  - rb_req  in  1  readback request.
  - rb_addr  in  IN_BITS  readback address.
  - rb_valid  out  1  readback result valid.
  - rb_data  out  OUT_BITS  readback result.

## Operation
- States:
  - IDLE: no table; reset state.
  - LOAD: accepting beats.
  - RUN: table valid, loaded=1.
- Beat counter: width IN_BITS - log2(ENTRIES), i.e. 32 beats at the defaults.
- Transfer occurs when cfg_valid && cfg_ready. Beat k, slice j writes address k*ENTRIES+j.
- Transitions:
  - IDLE or RUN with cfg_start: go to LOAD, clear the beat counter, drop loaded in the same edge.
  - LOAD, transfer on the last beat: go to RUN, pulse cfg_done, set loaded.
  - LOAD with cfg_start: restart the counter at 0, pulse err, stay in LOAD. Already-written entries are overwritten by the new load.
  - cfg_start in the same cycle as the last-beat transfer: the restart wins. The beat is not written, there is no cfg_done, and err pulses.
  - cfg_valid outside LOAD: ignored, no error.
- Lookup:
  - in_valid in RUN: out_valid=1 next cycle, with out_data = table[in_data].
  - in_valid outside RUN: out_valid=1 next cycle, with out_data=0 and err pulsed in that same cycle.
  - A lookup in the cycle that enters RUN sees state before the edge and is treated as not loaded.
- No backpressure on lookups; one result per cycle, full throughput.
- Table RAM is not reset. Contents after reset are don't-care until a full load completes.

## Timing
- Reset values: cfg_ready=0, cfg_done=0, loaded=0, out_valid=0, out_data=0, err=0, rb_valid=0, rb_data=0. State IDLE, counter 0.
- Reset asserted mid-load aborts the load; loaded stays 0 until a new complete load.
- cfg_ready rises the cycle after cfg_start is sampled, and falls in the cycle cfg_done pulses.
- A minimum full load takes 1 + 2^IN_BITS/ENTRIES cycles from cfg_start to cfg_done.
- Lookup latency: 1 cycle, registered output. out_data holds its value while out_valid=0.
- A write and a lookup never coincide, because lookups are only served in RUN.

## Configuration
- LUT_LOADER_READBACK_EN defined:
  - The rb_* ports exist.
  - rb_req in any state gives rb_valid=1 next cycle, with rb_data = table[rb_addr].
  - A readback in LOAD returns the current RAM contents without error.
  - Readback shares the RAM read port only logically; it has its own read mux and does not stall lookups.
- LUT_LOADER_READBACK_EN undefined: the rb_* ports and their logic are absent. No other behaviour changes.

## Test plan
- Reset, then in_valid with in_data=7'd5 -> out_valid=1 and out_data=2'b00 next cycle, err pulses once, loaded=0.
- cfg_start, then 32 back-to-back beats with entry a = a mod 4 (cfg_data=8'b11100100 each beat) -> cfg_done on the beat-31 edge, loaded=1. Then lookup 7'd93 -> 2'b01 one cycle later, and lookup 7'd127 -> 2'b11.
- Load with cfg_valid toggled every other cycle -> all 128 entries correct, and cfg_done occurs exactly once.
- cfg_start at beat 10, then a full reload with all entries 2'b10 -> err pulses once, and every lookup returns 2'b10.
- rst_n pulled low at beat 20 -> all outputs return to reset values immediately, and the lookup after reset errs.
- With LUT_LOADER_READBACK_EN: after the mod-4 load, rb_req with rb_addr=7'd6 -> rb_valid=1 and rb_data=2'b10 next cycle, concurrent with an unaffected lookup.
